// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller slice: arbiter state
// encoding, default timer width and the light/pedestrian codes.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } arb_state_e;

  localparam int TIMER_W = 4;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic PED_DONT_WALK = 1'b0;
  localparam logic PED_WALK      = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr,
// wrapping modulo NREQ.
module rr_pick
  import tlc_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx,
  output logic            any
);

  int   idx_s;
  logic hit_s;

  // Scan every offset from ptr; the first hit masks all later candidates.
  always_comb begin
    pick     = {NREQ{1'b0}};
    pick_idx = {PW{1'b0}};
    any      = 1'b0;
    idx_s    = 0;
    hit_s    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s    = (int'(ptr) + k >= NREQ) ? int'(ptr) + k - NREQ : int'(ptr) + k;
      hit_s    = req[idx_s] & ~any;
      pick[idx_s] = pick[idx_s] | hit_s;
      pick_idx = hit_s ? PW'(idx_s) : pick_idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/timer_share_arbiter.sv
// Shares one load/enable down-counter among NREQ requesters: round-robin
// grant, load, run to zero, then a one-cycle done pulse to the owner.
module timer_share_arbiter
  import tlc_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = TIMER_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_init,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            timer_en,
  output logic            timer_load,
  output logic [W-1:0]    timer_init,
  input  logic [W-1:0]    timer_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [W-1:0]    init_r, init_s;
  logic [PW-1:0]   ptr_r, ptr_s;

  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   pick_idx_s;
  logic            any_s;
  logic            owner_req_s;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req      (req),
    .ptr      (ptr_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .any      (any_s)
  );

  assign owner_req_s = |(req & gnt_r);

  // State, grant, latched interval and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gnt_r   <= {NREQ{1'b0}};
      init_r  <= {W{1'b0}};
      ptr_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      init_r  <= init_s;
      ptr_r   <= ptr_s;
    end
  end

  // Next-state logic; a dropped owner request cancels silently.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    init_s  = init_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_s = ST_LOAD;
          gnt_s   = pick_s;
          init_s  = req_init[int'(pick_idx_s)*W +: W];
          ptr_s   = (int'(pick_idx_s) == NREQ - 1) ? {PW{1'b0}} : pick_idx_s + PW'(32'd1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (owner_req_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = {NREQ{1'b0}};
        end
      end
      ST_RUN: begin
        if (!owner_req_s) begin
          state_s = ST_IDLE;
          gnt_s   = {NREQ{1'b0}};
        end else if (timer_out == {W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        gnt_s   = {NREQ{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {NREQ{1'b0}};
      end
    endcase
  end

  // Output decode from registered state; timer_en also guards underflow.
  always_comb begin
    gnt        = gnt_r;
    timer_init = init_r;
    busy       = (state_r != ST_IDLE);
    timer_load = (state_r == ST_LOAD);
    if (state_r == ST_RUN) begin
      timer_en = (timer_out != {W{1'b0}});
    end else begin
      timer_en = 1'b0;
    end
    if (state_r == ST_DONE) begin
      done = gnt_r;
    end else begin
      done = {NREQ{1'b0}};
    end
  end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Self-checking bench: timeline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_timer_share_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_init = '0;
  logic [NREQ-1:0]   gnt, done;
  logic              busy, timer_en, timer_load;
  logic [W-1:0]      timer_init;
  logic [W-1:0]      timer_out = '0;

  int n_checks = 0;
  int n_pass   = 0;

  timer_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_init   (req_init),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .timer_en   (timer_en),
    .timer_load (timer_load),
    .timer_init (timer_init),
    .timer_out  (timer_out)
  );

  always #5 clk = ~clk;

  // The shared timer itself (not reset by the arbiter).
  always @(posedge clk) begin
    if (timer_load) timer_out <= timer_init;
    else if (timer_en) timer_out <= timer_out - 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner index (-1 idle), cycles since grant, interval.
  int           m_owner, m_t, m_len, m_ptr;
  logic [W-1:0] m_init;

  function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_t <= 0; m_len <= 0; m_ptr <= 0; m_init <= '0;
    end else if (m_owner < 0) begin
      if (rr_first(req, m_ptr) >= 0) begin
        m_owner <= rr_first(req, m_ptr);
        m_t     <= 1;
        m_len   <= int'(req_init[rr_first(req, m_ptr)*W +: W]);
        m_init  <= req_init[rr_first(req, m_ptr)*W +: W];
        m_ptr   <= (rr_first(req, m_ptr) + 1) % NREQ;
      end
    end else if (m_t <= m_len + 2 && !req[m_owner]) begin
      m_owner <= -1;
    end else if (m_t == m_len + 3) begin
      m_owner <= -1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("timer_load", 32'(timer_load), 32'(m_owner >= 0 && m_t == 1));
      check("timer_en", 32'(timer_en), 32'(m_owner >= 0 && m_t >= 2 && m_t < m_len + 2));
      check("done", 32'(done), (m_owner >= 0 && m_t == m_len + 3) ? (32'd1 << m_owner) : 32'd0);
      check("timer_init", 32'(timer_init), 32'(m_init));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_init(input int i, input int v);
    req_init[i*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);
  endtask

  logic en_seen;

  initial begin
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'({done, timer_en, timer_load, timer_init}), 32'd0);

    // Single request, init 4
    do_reset();
    set_init(0, 4); req = 3'b001;
    wait_cyc(1); check("t1_load", 32'(timer_load), 32'd1);
    wait_cyc(6); check("t1_done", 32'(done), 32'b001);
    req = '0;
    wait_cyc(1); check("t1_idle", 32'(busy), 32'd0);

    // Fairness, all inits 2
    do_reset();
    set_init(0, 2); set_init(1, 2); set_init(2, 2); req = 3'b111;
    wait_cyc(1); check("fair_g0", 32'(gnt), 32'b001);
    wait_cyc(4); check("fair_d0", 32'(done), 32'b001);
    wait_cyc(1); check("fair_d0_off", 32'(done), 32'b000);
    wait_cyc(1); check("fair_g1", 32'(gnt), 32'b010);
    wait_cyc(6); check("fair_g2", 32'(gnt), 32'b100);
    wait_cyc(6); check("fair_g3", 32'(gnt), 32'b001);
    req = '0;
    wait_cyc(2);

    // Zero interval on requester 1
    do_reset();
    set_init(1, 0); req = 3'b010;
    en_seen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      wait_cyc(1);
      en_seen = en_seen | timer_en;
      if (c == 3) check("zero_done", 32'(done), 32'b010);
    end
    check("zero_no_en", 32'(en_seen), 32'd0);
    req = '0;

    // Cancel in RUN with timer_out 5
    do_reset();
    set_init(0, 7); set_init(1, 3); req = 3'b011;
    wait_cyc(4); check("cxl_tout", 32'(timer_out), 32'd5);
    req = 3'b010;
    wait_cyc(1); check("cxl_idle", 32'({busy, gnt, done}), 32'd0);
    wait_cyc(1); check("cxl_next", 32'(gnt), 32'b010);
    wait_cyc(5); check("cxl_done", 32'(done), 32'b010);
    req = '0;

    // req_init latched at grant
    do_reset();
    set_init(0, 9); req = 3'b001;
    wait_cyc(1); set_init(0, 1);
    wait_cyc(4); check("latch_init", 32'(timer_init), 32'd9);
    wait_cyc(6); check("latch_early", 32'(done), 32'b000);
    wait_cyc(1); check("latch_done", 32'(done), 32'b001);
    req = '0;

    // Async reset mid-RUN
    do_reset();
    set_init(0, 6); req = 3'b001;
    wait_cyc(4);
    #2 rst = 1'b1;
    #1 check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_en", 32'(timer_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk); rst = 1'b0;
    wait_cyc(1);
    req = 3'b011;
    wait_cyc(1); check("arst_regrant", 32'(gnt), 32'b001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wait_cyc(1);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 5) == 0)
          set_init(i, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)));
      end
    end
    req = '0;
    wait_cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_share_arbiter.md
# timer_share_arbiter

Sequencer and round-robin arbiter that shares the single load/enable down-counter `timer` between several timed requesters, e.g. the traffic light controller's phase timing and a pedestrian walk countdown. Each requester asks for an interval; the arbiter grants one, loads and runs the timer, and reports completion with a one-cycle `done` pulse. It sits between the requesters and the `timer` instance, and exclusively drives the timer's `en`, `load` and `init` inputs.

## Interface
- `NREQ`, default 3: number of requesters (2..8).
- `W`, default 4: timer width in bits; matches `timer.init` and `timer.out`.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  `req[i]` high requests an interval; held until `done[i]` (dropping it early cancels).
- `req_init`  in  NREQ*W  flattened intervals; slice i is `req_init[i*W +: W]`.
- `gnt`  out  NREQ  one-hot current owner, zero when idle.
- `done`  out  NREQ  one-hot, one-cycle pulse when owner's interval expires.
- `busy`  out  1  high whenever state is not IDLE.
- `timer_en`  out  1  to `timer.en`.
- `timer_load`  out  1  to `timer.load`.
- `timer_init`  out  W  to `timer.init`.
- `timer_out`  in  W  from `timer.out`.

## Operation
- Timer contract: on a rising edge, `load` makes `out` = `init`. `load` has priority over `en`. Otherwise `en` decrements `out` by 1.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if any `req` bit is high, pick the winner round-robin, starting the search at pointer `ptr`. Register `gnt` one-hot, latch the winner's `req_init` slice into `timer_init`, set `ptr` = (winner+1) mod NREQ, and go to LOAD. With no requests, stay in IDLE.
- LOAD: `timer_load`=1 and `timer_en`=0, then go to RUN.
- RUN: `timer_en` = (`timer_out` != 0). If `timer_out`==0, go to DONE.
- DONE: `done` = `gnt` for this one cycle, `timer_en`=0, then go to IDLE and clear `gnt`.
- Cancel: if `req[owner]` is low during LOAD or RUN, go to IDLE next edge. Clear `gnt`, produce no `done` and leave `ptr` as already advanced.
- `req_init` changes after the grant have no effect, because `timer_init` is latched.
- New requests arriving in LOAD/RUN/DONE wait; they are considered in the next IDLE cycle.
- The arbiter never drives `timer_en` while `timer_out`==0, so the timer does not underflow.

## Timing
- Reset (async) values: state IDLE, `gnt`=0, `done`=0, `busy`=0, `timer_en`=0, `timer_load`=0, `timer_init`=0, `ptr`=0.
- Reset mid-operation aborts immediately with no `done`. The timer is not reset by this block; the next LOAD overwrites it.
- Latency, with `req` seen in IDLE in cycle 0:
  - LOAD in cycle 1.
  - RUN from cycle 2, with `timer_out`=init.
  - `timer_out` reaches 0 in cycle 2+init.
  - DONE (`done` pulse) in cycle 3+init.
  - IDLE in cycle 4+init.
- init=0: RUN sees 0 immediately, so DONE comes in cycle 3.
- Minimum gap between back-to-back grants: the second requester's LOAD is in cycle 5+init, one IDLE cycle after DONE.
- All outputs are registered-state decodes; there is no combinational path from `req` to outputs.

## Structure
- Package `tlc_pkg` holds:
  - the state encoding constants (IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11);
  - the default timer width `TIMER_W`=4;
  - the light and pedestrian code constants shared with `traffic_light_controller`.
- Sub-module `rr_pick` is a combinational round-robin selector. Inputs: `req[NREQ]`, `ptr`. Outputs: one-hot `pick`, `pick_idx`, `any`. It is instantiated once.

## Test plan
- Single request: `req`=3'b001 with init 4 → `timer_load` in cycle 1, `done`=3'b001 in cycle 7, `busy` low in cycle 8.
- Fairness: `req`=3'b111 held, all inits 2 → grants in order 001, 010, 100, 001; each `done` exactly one cycle.
- Zero interval: init 0 on requester 1 → `done`=3'b010 in cycle 3, and `timer_en` never asserts.
- Cancel: drop `req[0]` in RUN with `timer_out`=5 → IDLE next edge, no `done`; pending `req[1]` is granted next (`ptr`=1).
- Latch check: change `req_init` slice from 9 to 1 in the cycle after the grant → the interval still runs 9 counts; `done` in cycle 12.
- Async reset mid-RUN: assert `rst` between edges → `gnt`, `timer_en`, `busy` go 0 immediately. After release, a fresh request is granted starting from requester 0.
